// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer: shifter state encoding.
package bit_serializer_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: valid/ready word input, one bit per clock out,
// with a one-word hold buffer so back-to-back words stream without a gap.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done,
  output logic             idle
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_valid_q, ser_valid_d;
  logic             word_done_q, word_done_d;
  logic             idle_q, idle_d;
  logic             accept;
  logic             last_bit;

  assign in_ready = !hold_full_q && !rst;
  assign accept   = in_valid && in_ready;
  assign last_bit = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          shift_d = in_data;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (last_bit) begin
          // A full hold buffer forces in_ready low, so the two reload
          // sources below are mutually exclusive.
          if (hold_full_q) begin
            shift_d     = hold_q;
            cnt_d       = '0;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shift_d = in_data;
            cnt_d   = '0;
          end else begin
            shift_d = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          shift_d = advance(shift_q);
          cnt_d   = cnt_q + CNT_W'(1);
          if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ser_valid_d = (state_d == S_SHIFT);
    ser_bit_d   = (state_d == S_SHIFT) ? head_bit(shift_d) : 1'b0;
    word_done_d = (state_d == S_SHIFT) && (cnt_d == CNT_LAST);
    idle_d      = (state_d == S_IDLE) && !hold_full_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      word_done_q <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ser_bit_q   <= ser_bit_d;
      ser_valid_q <= ser_valid_d;
      word_done_q <= word_done_d;
      idle_q      <= idle_d;
    end
  end

  assign ser_bit   = ser_bit_q;
  assign ser_valid = ser_valid_q;
  assign word_done = word_done_q;
  assign idle      = idle_q;

endmodule
